// File: rtl/melody_if.sv
// Handshake bundle between the alarm logic and the melody sequencer.
// The alarm side drives start/stop; the sequencer drives the tone outputs.
interface melody_if;
  logic       start;
  logic       stop;
  logic [5:0] music;
  logic       playing;
  logic       done;
  logic [4:0] note_addr;

  modport master (
    output start, stop,
    input  music, playing, done, note_addr
  );

  modport slave (
    input  start, stop,
    output music, playing, done, note_addr
  );
endinterface

// File: rtl/melody_sequencer.sv
// Melody sequencer: walks a fixed (note, duration) song table with a silent gap.
// Define MELODY_LOOP_EN to restart the song instead of ending with a done pulse.
module melody_sequencer #(
  parameter int unsigned TICKS_PER_BEAT = 12_500_000,
  parameter int unsigned GAP_TICKS      = 500_000,
  parameter logic [5:0]  REST_CODE      = 6'd63
) (
  input  logic     clk,
  input  logic     rst_n,
  melody_if.slave  mif
);

  localparam logic [31:0] TPB    = 32'(TICKS_PER_BEAT);
  localparam logic [31:0] GAP_LD = 32'(GAP_TICKS) - 32'd1;

  typedef enum logic [1:0] {IDLE, NOTE, GAP} state_t;

  state_t      state;
  logic [31:0] cnt;
  logic [4:0]  addr;

  logic [9:0]  s_ent;
  logic [9:0]  f_ent;
  state_t      f_state;
  logic [5:0]  f_music;
  logic        f_play;
  logic [4:0]  f_addr;
  logic [31:0] f_cnt;
  logic        f_done;

  // Song table entry {note[5:0], dur[3:0]}; dur 0 marks the end.
  function automatic logic [9:0] rom(input logic [4:0] a);
    logic [9:0] e;
    case (a)
      5'd0:    e = {6'd12, 4'd2};
      5'd1:    e = {6'd16, 4'd2};
      5'd2:    e = {6'd19, 4'd4};
      5'd3:    e = {6'd63, 4'd1};
      default: e = 10'd0;
    endcase
    return e;
  endfunction

  function automatic logic [31:0] dur_ld(input logic [3:0] d);
    return ({28'd0, d} * TPB) - 32'd1;
  endfunction

  assign mif.note_addr = addr;

  // Next-entry fetch: either the following note or the end-of-song action.
  always_comb begin
    s_ent   = rom(5'd0);
    f_addr  = addr + 5'd1;
    f_ent   = rom(f_addr);
    f_state = NOTE;
    f_music = f_ent[9:4];
    f_play  = 1'b1;
    f_cnt   = dur_ld(f_ent[3:0]);
    f_done  = 1'b0;
    if (f_ent[3:0] == 4'd0) begin
`ifdef MELODY_LOOP_EN
      f_addr  = 5'd0;
      f_music = s_ent[9:4];
      f_cnt   = dur_ld(s_ent[3:0]);
`else
      f_state = IDLE;
      f_music = REST_CODE;
      f_play  = 1'b0;
      f_addr  = 5'd0;
      f_cnt   = 32'd0;
      f_done  = 1'b1;
`endif
    end
  end

  // Playback FSM with registered outputs; stop overrides everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= 32'd0;
      addr        <= 5'd0;
      mif.music   <= REST_CODE;
      mif.playing <= 1'b0;
      mif.done    <= 1'b0;
    end else begin
      mif.done <= 1'b0;
      if (mif.stop) begin
        state       <= IDLE;
        cnt         <= 32'd0;
        addr        <= 5'd0;
        mif.music   <= REST_CODE;
        mif.playing <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (mif.start) begin
              state       <= NOTE;
              addr        <= 5'd0;
              cnt         <= dur_ld(s_ent[3:0]);
              mif.music   <= s_ent[9:4];
              mif.playing <= 1'b1;
            end
          end
          NOTE, GAP: begin
            if (cnt != 32'd0) begin
              cnt <= cnt - 32'd1;
            end else if (state == NOTE && GAP_TICKS > 0) begin
              state     <= GAP;
              cnt       <= GAP_LD;
              mif.music <= REST_CODE;
            end else begin
              state       <= f_state;
              addr        <= f_addr;
              cnt         <= f_cnt;
              mif.music   <= f_music;
              mif.playing <= f_play;
              mif.done    <= f_done;
            end
          end
          default: begin
            state       <= IDLE;
            cnt         <= 32'd0;
            addr        <= 5'd0;
            mif.music   <= REST_CODE;
            mif.playing <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_melody_sequencer.sv
// Bench for melody_sequencer: vector table, song scoreboard, abort/reset cases.
// Two instances: GAP_TICKS=1 and GAP_TICKS=0, both with TICKS_PER_BEAT=4.
module tb_melody_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  melody_if ifa ();
  melody_if ifb ();

  melody_sequencer #(
    .TICKS_PER_BEAT(4),
    .GAP_TICKS(1),
    .REST_CODE(6'd63)
  ) dut_a (
    .clk(clk),
    .rst_n(rst_n),
    .mif(ifa)
  );

  melody_sequencer #(
    .TICKS_PER_BEAT(4),
    .GAP_TICKS(0),
    .REST_CODE(6'd63)
  ) dut_b (
    .clk(clk),
    .rst_n(rst_n),
    .mif(ifb)
  );

  always #5 clk = ~clk;

  int nchk = 0;
  int npass = 0;
  int expq[$];

  typedef struct {
    logic start;
    logic stop;
    int   music;
    int   playing;
    int   done;
  } vec_t;

  vec_t vt[7];

  task automatic chk(input string nm, input int act, input int exp);
    nchk++;
    if (act == exp) npass++;
    else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input int sel, output int m, output int p,
                    output int d, output int a);
    if (sel == 0) begin
      m = int'(ifa.music);
      p = int'(ifa.playing);
      d = int'(ifa.done);
      a = int'(ifa.note_addr);
    end else begin
      m = int'(ifb.music);
      p = int'(ifb.playing);
      d = int'(ifb.done);
      a = int'(ifb.note_addr);
    end
  endtask

  task automatic push_song(input int gap);
    int sn[4] = '{12, 16, 19, 63};
    int sd[4] = '{2, 2, 4, 1};
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < sd[i] * 4; j++) expq.push_back(sn[i]);
      for (int j = 0; j < gap; j++) expq.push_back(63);
    end
  endtask

  task automatic play(input int sel, input int gap, input string tag,
                      input bit hold);
    int m, p, d, a, n;
    push_song(gap);
    n = expq.size();
    if (sel == 0) ifa.start = 1'b1;
    else ifb.start = 1'b1;
    step();
    if (!hold) begin
      ifa.start = 1'b0;
      ifb.start = 1'b0;
    end
    for (int k = 0; k < n; k++) begin
      rd(sel, m, p, d, a);
      chk({tag, " music"}, m, expq.pop_front());
      chk({tag, " playing"}, p, 1);
      chk({tag, " done"}, d, 0);
      step();
    end
    rd(sel, m, p, d, a);
`ifdef MELODY_LOOP_EN
    chk({tag, " loop music"}, m, 12);
    chk({tag, " loop playing"}, p, 1);
    chk({tag, " loop done"}, d, 0);
    chk({tag, " loop addr"}, a, 0);
`else
    chk({tag, " end done"}, d, 1);
    chk({tag, " end playing"}, p, 0);
    chk({tag, " end music"}, m, 63);
    chk({tag, " end addr"}, a, 0);
`endif
  endtask

  task automatic stop_pulse(input int sel);
    int m, p, d, a;
    if (sel == 0) ifa.stop = 1'b1;
    else ifb.stop = 1'b1;
    step();
    ifa.stop = 1'b0;
    ifb.stop = 1'b0;
    rd(sel, m, p, d, a);
    chk("stop music", m, 63);
    chk("stop playing", p, 0);
  endtask

  initial begin
    int m, p, d, a;
    int seen;

    vt[0] = '{1'b1, 1'b1, 63, 0, 0};
    vt[1] = '{1'b0, 1'b0, 63, 0, 0};
    vt[2] = '{1'b1, 1'b0, 12, 1, 0};
    vt[3] = '{1'b1, 1'b0, 12, 1, 0};
    vt[4] = '{1'b0, 1'b0, 12, 1, 0};
    vt[5] = '{1'b0, 1'b1, 63, 0, 0};
    vt[6] = '{1'b0, 1'b0, 63, 0, 0};

    ifa.start = 1'b0;
    ifa.stop  = 1'b0;
    ifb.start = 1'b0;
    ifb.stop  = 1'b0;
    #12 rst_n = 1'b1;
    step();

    rd(0, m, p, d, a);
    chk("reset music", m, 63);
    chk("reset playing", p, 0);
    chk("reset done", d, 0);
    chk("reset addr", a, 0);

    for (int i = 0; i < 7; i++) begin
      ifa.start = vt[i].start;
      ifa.stop  = vt[i].stop;
      step();
      rd(0, m, p, d, a);
      chk($sformatf("vec%0d music", i), m, vt[i].music);
      chk($sformatf("vec%0d playing", i), p, vt[i].playing);
      chk($sformatf("vec%0d done", i), d, vt[i].done);
    end
    ifa.start = 1'b0;
    ifa.stop  = 1'b0;

    play(0, 1, "song", 1'b0);
`ifndef MELODY_LOOP_EN
    step();
    rd(0, m, p, d, a);
    chk("song done width", d, 0);
`endif
    stop_pulse(0);

    ifa.start = 1'b1;
    step();
    ifa.start = 1'b0;
    repeat (11) step();
    rd(0, m, p, d, a);
    chk("abort pre music", m, 16);
    chk("abort pre addr", a, 1);
    ifa.stop = 1'b1;
    step();
    ifa.stop = 1'b0;
    rd(0, m, p, d, a);
    chk("abort music", m, 63);
    chk("abort playing", p, 0);
    chk("abort addr", a, 0);
    seen = 0;
    repeat (50) begin
      step();
      rd(0, m, p, d, a);
      if (d != 0) seen = 1;
    end
    chk("abort no done", seen, 0);

    play(0, 1, "hold", 1'b1);
    step();
    rd(0, m, p, d, a);
    chk("hold restart music", m, 12);
    chk("hold restart playing", p, 1);
    ifa.start = 1'b0;
    stop_pulse(0);

    play(1, 0, "gap0", 1'b0);
    stop_pulse(1);

    ifa.start = 1'b1;
    step();
    ifa.start = 1'b0;
    repeat (3) step();
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    rd(0, m, p, d, a);
    chk("async rst music", m, 63);
    chk("async rst playing", p, 0);
    chk("async rst done", d, 0);
    chk("async rst addr", a, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    rd(0, m, p, d, a);
    chk("post rst music", m, 63);

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule

// File: doc/melody_sequencer.md
Name: melody_sequencer

Overview:
- Upstream driver of the tone generator. Steps through a fixed on-chip song table of (note, duration) entries and drives the tone generator's 6-bit note index.
- Inserts a short silent gap between entries so repeated notes stay distinct.
- Started by the alarm logic and stoppable at any time; reports completion.

Parameters:
TICKS_PER_BEAT, 12_500_000, clk cycles per duration unit (0.25 s at 50 MHz); must be >=1
GAP_TICKS, 500_000, clk cycles of silence after every entry; 0 = no gap
REST_CODE, 63, note index output for silence (outside tone range 0..27)

Ports:
clk  input  1  system clock, 50 MHz
rst_n  input  1  asynchronous active-low reset
start  input  1  level sampled each clk; begins playback from entry 0 when IDLE
stop  input  1  level sampled each clk; aborts playback
music  output  6  note index to tone generator; REST_CODE when silent
playing  output  1  high while in NOTE or GAP
done  output  1  one-cycle pulse on natural end of song
note_addr  output  5  current table address (debug/display)

Behaviour:
- Reset (async, rst_n=0): state IDLE, music=REST_CODE, playing=0, done=0, note_addr=0, tick counter=0.
- Song table: 32 entries, combinational read, each entry {note[5:0], dur[3:0]}. dur=0 is the end marker.
- Fixed contents: 0:{12,2} 1:{16,2} 2:{19,4} 3:{63,1} 4:{end}. Entries 5..31 are {end}.
- State register updates on posedge clk.
- IDLE:
  - start=1 and stop=0 → NOTE with addr=0.
  - On that edge: music=note[0], playing=1, counter loaded with dur*TICKS_PER_BEAT-1.
- NOTE:
  - music holds the entry note; counter decrements each cycle.
  - The note lasts exactly dur*TICKS_PER_BEAT cycles.
  - At counter=0: if GAP_TICKS>0 → GAP (music=REST_CODE, counter=GAP_TICKS-1); else fetch the next entry directly.
- GAP:
  - music=REST_CODE for exactly GAP_TICKS cycles.
  - At counter=0: addr increments and the next entry is fetched.
- Fetch of a dur!=0 entry: → NOTE as above, in the same edge. No idle cycle between entries.
- Fetch of an end marker: → IDLE; music=REST_CODE, playing=0, addr=0; done=1 for exactly that one cycle.
- Address wrap: addr 31 increments to 0. This is only reachable if entry 31 is non-end, which it is not in the fixed table.
- stop=1 in any state: next edge → IDLE, music=REST_CODE, playing=0, addr=0, done=0. No done pulse.
- Priorities:
  - stop beats start when both are high in the same cycle.
  - start while playing is ignored (no restart).
- Duration arithmetic: counter is 32 bits; dur*TICKS_PER_BEAT is computed at 32-bit width. Parameters must keep 15*TICKS_PER_BEAT < 2^32.
- Rest entries (note=REST_CODE) are timed exactly like notes.
- music is registered, with no combinational path from start/stop to music.

Optional Feature:
- MELODY_LOOP_EN defined: an end-marker fetch returns to addr 0 and enters NOTE with entry 0 in the same edge.
  - playing stays 1 and done is never asserted.
  - Only stop or reset ends playback.
- Not defined: end-of-song behaviour exactly as in Behaviour (IDLE + done pulse).

Test Plan:
All tests use TICKS_PER_BEAT=4 and GAP_TICKS=1 unless stated.
- Reset: rst_n=0 asynchronously mid-clock → music=63, playing=0, done=0, note_addr=0 immediately, without waiting for a clk edge.
- Full song: 1-cycle start pulse → music sequence 12×8, 63×1, 16×8, 63×1, 19×16, 63×1, 63×4, 63×1 cycles (40 total) → then playing=0 and done=1 for exactly 1 cycle; note_addr returns to 0.
- Abort: stop=1 during the 3rd cycle of note 16 → next edge music=63, playing=0; done stays 0 for 50 following cycles.
- Priorities:
  - start held high throughout playback → song plays once unchanged and done pulses once; playback restarts on the following cycle because start is still high.
  - start=stop=1 in IDLE → remains IDLE, music=63.
- GAP_TICKS=0: start pulse → 12×8, 16×8, 19×16, 63×4 cycles back-to-back (36 total), then done pulse.
- MELODY_LOOP_EN defined: after the 40-cycle song, music=12 again on the next cycle, playing=1, done never asserted; stop then → music=63, playing=0.
